// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg: base scalar types shared across the RV32 front end
package rv32i_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/rv32v_types_pkg.sv
// rv32v_types_pkg: fetch2 slot layout and ring pointer sizing
package rv32v_types_pkg;
    import rv32i_types_pkg::*;

    typedef struct packed {
        word_t pc;
        word_t rdata;
        logic  mal;
        logic  fault;
    } fetch2_entry_t;

    localparam int FETCH2_DEPTH = 2;
    localparam int FETCH2_PTR_W = $clog2(FETCH2_DEPTH) + 1;

    // One extra bit beyond the index distinguishes full from empty
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/rv32v_fetch2_ring.sv
// rv32v_fetch2_ring: in-order slot storage with allocate, fill and pop pointers
module rv32v_fetch2_ring
    import rv32v_types_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = ptr_width(DEPTH)
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               flush,
    input  logic                               alloc,
    input  logic [31:0]                        alloc_pc,
    input  logic                               fill,
    input  logic [31:0]                        fill_rdata,
    input  logic                               fill_fault,
    input  logic                               pop,
    output logic [PW-1:0]                      wr_ptr,
    output logic [PW-1:0]                      fill_ptr,
    output logic [PW-1:0]                      rd_ptr,
    output logic [$bits(fetch2_entry_t)-1:0]   head
);
    localparam int AW = PW - 1;

    fetch2_entry_t mem [DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
        end else begin
            if (alloc) begin
                mem[wr_ptr[AW-1:0]].pc  <= alloc_pc;
                mem[wr_ptr[AW-1:0]].mal <= |alloc_pc[1:0];
                wr_ptr                  <= wr_ptr + 1'b1;
            end
            if (fill) begin
                mem[fill_ptr[AW-1:0]].rdata <= fill_rdata;
                mem[fill_ptr[AW-1:0]].fault <= fill_fault;
                fill_ptr                    <= fill_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/rv32v_fetch2_stage.sv
// rv32v_fetch2_stage: tracks imem requests in order, captures responses and
// hands instructions to decode, dropping responses orphaned by a flush
module rv32v_fetch2_stage
    import rv32v_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        f1_req_valid,
    input  logic [31:0] f1_pc,
    output logic        f1_req_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    input  logic        flush,
    output logic        dec_valid,
    input  logic        dec_stall,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        mal_insn,
    output logic        fault_insn
);
    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0] wr_ptr, fill_ptr, rd_ptr, drop_cnt, used, pend;
    logic          alloc, fill, pop, dropping;
    fetch2_entry_t head;

    assign used     = wr_ptr - rd_ptr;
    assign pend     = wr_ptr - fill_ptr;
    assign dropping = imem_rvalid && drop_cnt != '0;
    // Stale responses still occupy memory bandwidth, so they count against capacity
    assign f1_req_ready = !RST && !flush &&
                          ({1'b0, used} + {1'b0, drop_cnt} < (PW+1)'(DEPTH));
    assign alloc = f1_req_valid && f1_req_ready;
    assign fill  = imem_rvalid && !dropping && pend != '0 && !flush;
    assign pop   = dec_valid && !dec_stall;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) drop_cnt <= '0;
        else if (flush) drop_cnt <= drop_cnt + pend - PW'(imem_rvalid);
        else if (dropping) drop_cnt <= drop_cnt - 1'b1;
    end

    rv32v_fetch2_ring #(.DEPTH(DEPTH)) u_ring (
        .CLK(CLK),
        .RST(RST),
        .flush(flush),
        .alloc(alloc),
        .alloc_pc(f1_pc),
        .fill(fill),
        .fill_rdata(imem_rdata),
        .fill_fault(imem_error),
        .pop(pop),
        .wr_ptr(wr_ptr),
        .fill_ptr(fill_ptr),
        .rd_ptr(rd_ptr),
        .head(head)
    );

    assign dec_valid  = rd_ptr != fill_ptr;
    assign pc         = dec_valid ? head.pc : '0;
    assign mal_insn   = dec_valid && head.mal;
    assign fault_insn = dec_valid && head.fault;
    assign instr      = (dec_valid && !head.mal && !head.fault) ? head.rdata : '0;
endmodule

// File: tb/tb_rv32v_fetch2_stage.sv
// tb_rv32v_fetch2_stage: directed and random traffic against a queue-based model
module tb_rv32v_fetch2_stage;
    localparam int DEPTH = 2;

    logic        CLK = 0, RST = 1;
    logic        f1_req_valid = 0, imem_rvalid = 0, imem_error = 0, flush = 0, dec_stall = 0;
    logic [31:0] f1_pc = 0, imem_rdata = 0;
    logic        f1_req_ready, dec_valid, mal_insn, fault_insn;
    logic [31:0] instr, pc;

    rv32v_fetch2_stage #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .f1_req_valid(f1_req_valid), .f1_pc(f1_pc), .f1_req_ready(f1_req_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_error(imem_error),
        .flush(flush), .dec_valid(dec_valid), .dec_stall(dec_stall),
        .instr(instr), .pc(pc), .mal_insn(mal_insn), .fault_insn(fault_insn)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        mal;
        logic        fault;
    } ent_t;

    ent_t items[$];
    int   nfill = 0, drop = 0, mem_pending = 0;
    int   n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        items.delete();
        nfill = 0;
        drop = 0;
        mem_pending = 0;
    endtask

    task automatic step(input logic v, input logic [31:0] p, input logic rv,
                        input logic [31:0] rd, input logic er, input logic fl, input logic st);
        logic rdy, dv;
        ent_t h, t;
        @(posedge CLK);
        #1;
        f1_req_valid = v; f1_pc = p; imem_rvalid = rv; imem_rdata = rd;
        imem_error = er; flush = fl; dec_stall = st;
        #1;
        rdy = !fl && (items.size() + drop < DEPTH);
        dv  = nfill > 0;
        h   = dv ? items[0] : '{32'h0, 32'h0, 1'b0, 1'b0};
        check("ready", 32'(f1_req_ready), 32'(rdy));
        check("dec_valid", 32'(dec_valid), 32'(dv));
        check("pc", pc, h.pc);
        check("mal", 32'(mal_insn), 32'(h.mal));
        check("fault", 32'(fault_insn), 32'(h.fault));
        check("instr", instr, (h.mal || h.fault) ? 32'h0 : h.rdata);
        check("drop_cnt", 32'(dut.drop_cnt), 32'(drop));
        if (rv) mem_pending--;
        if (fl) begin
            drop = drop + (items.size() - nfill) - (rv ? 1 : 0);
            items.delete();
            nfill = 0;
        end else begin
            if (rv) begin
                if (drop > 0) drop--;
                else if (nfill < items.size()) begin
                    t = items[nfill];
                    t.rdata = rd;
                    t.fault = er;
                    items[nfill] = t;
                    nfill++;
                end
            end
            if (dv && !st) begin
                void'(items.pop_front());
                nfill--;
            end
            if (v && rdy) items.push_back('{p, 32'h0, p[1:0] != 2'b00, 1'b0});
        end
        if (v && rdy) mem_pending++;
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, st);
    endtask

    initial begin
        #3;
        check("ready_in_reset", 32'(f1_req_ready), 32'h0);
        check("dec_valid_in_reset", 32'(dec_valid), 32'h0);
        #10 RST = 0;

        // basic flow
        step(1, 32'h100, 0, 0, 0, 0, 0);
        step(1, 32'h104, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h00000013, 0, 0, 0);
        step(0, 0, 1, 32'h00A00093, 0, 0, 0);
        idle(3, 0);

        // full / backpressure
        step(1, 32'h100, 0, 0, 0, 0, 1);
        step(1, 32'h104, 0, 0, 0, 0, 1);
        step(1, 32'h108, 1, 32'h11111111, 0, 0, 1);
        step(1, 32'h108, 1, 32'h22222222, 0, 0, 1);
        step(1, 32'h108, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(2, 0);

        // misaligned then faulting fetch
        step(1, 32'h102, 0, 0, 0, 0, 0);
        step(1, 32'h108, 1, 32'h00000013, 0, 0, 0);
        step(0, 0, 1, 32'hDEADBEEF, 1, 0, 0);
        idle(3, 0);

        // flush with two in flight
        step(1, 32'h300, 0, 0, 0, 0, 0);
        step(1, 32'h304, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 32'h200, 1, 32'hBAD00001, 0, 0, 0);
        step(1, 32'h200, 1, 32'hBAD00002, 0, 0, 0);
        step(1, 32'h200, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h00500113, 0, 0, 0);
        idle(3, 0);

        // flush coincident with a response
        step(1, 32'h400, 0, 0, 0, 0, 0);
        step(1, 32'h404, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hBAD00003, 0, 1, 0);
        step(1, 32'h500, 1, 32'hBAD00004, 0, 0, 0);
        step(0, 0, 1, 32'h00600193, 0, 0, 0);
        idle(3, 0);

        // async reset with two buffered entries
        step(1, 32'h600, 0, 0, 0, 0, 1);
        step(1, 32'h604, 0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h0A0A0A0A, 0, 0, 1);
        step(0, 0, 1, 32'h0B0B0B0B, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        #1 RST = 1;
        f1_req_valid = 0; imem_rvalid = 0; flush = 0; dec_stall = 0;
        #1;
        check("rst_dec_valid", 32'(dec_valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_mal", 32'(mal_insn), 32'h0);
        check("rst_fault", 32'(fault_insn), 32'h0);
        check("rst_ready", 32'(f1_req_ready), 32'h0);
        model_reset();
        @(posedge CLK);
        #3 RST = 0;
        step(1, 32'h700, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h00700213, 0, 0, 0);
        idle(2, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] p;
            logic        rv;
            p  = ($urandom & 32'hFFFF_FFFC) | (($urandom % 8 == 0) ? 32'h2 : 32'h0);
            rv = (mem_pending > 0) && ($urandom % 2 == 0);
            step($urandom % 2 == 0, p, rv, $urandom, $urandom % 10 == 0,
                 $urandom % 30 == 0, $urandom % 3 == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rv32v_fetch2_stage.md
# rv32v_fetch2_stage

Second fetch stage of the RV32V vector front end. It allocates an in-order slot for every instruction-memory request that fetch1 issues, captures each response into that slot, and flags misaligned PCs and bus faults. It then presents instructions, oldest first, to decode with a valid/stall handshake. It sits between fetch1 and the instruction memory on the input side and drives the fetch-to-decode signals (instr, mal_insn, fault_insn) on the output side.

## Interface
Parameters:
- DEPTH, 2: slots in the ring; must be a power of two ≥ 2.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- f1_req_valid  in  1  fetch1 issues a memory request this cycle.
- f1_pc  in  32  PC of that request.
- f1_req_ready  out  1  slot available; a request is accepted when valid && ready.
- imem_rvalid  in  1  memory response valid; responses return in request order.
- imem_rdata  in  32  response instruction word.
- imem_error  in  1  bus error on this response.
- flush  in  1  redirect: discard all buffered and in-flight instructions.
- dec_valid  out  1  head instruction valid for decode.
- dec_stall  in  1  decode not accepting; a pop happens when dec_valid && !dec_stall.
- instr  out  32  head instruction word.
- pc  out  32  head PC.
- mal_insn  out  1  head PC[1:0] != 0.
- fault_insn  out  1  head response had imem_error.

## Operation
- Ring state:
  - DEPTH entries {pc, rdata, mal, fault}.
  - Three pointers, each log2(DEPTH)+1 bits wide and wrapping naturally:
    - wr_ptr: allocate.
    - fill_ptr: response.
    - rd_ptr: pop.
  - Invariant: rd ≤ fill ≤ wr (modular); wr−rd ≤ DEPTH.
- Allocate (f1_req_valid && f1_req_ready): write pc into slot wr_ptr, set mal = f1_pc[1:0] != 0, then wr_ptr++.
- Response (imem_rvalid):
  - If drop_cnt > 0: the response is discarded and drop_cnt−−.
  - Else, if fill_ptr != wr_ptr: write rdata and fault into slot fill_ptr, then fill_ptr++.
  - Else (no outstanding request): protocol error; the response is ignored.
- Pop: rd_ptr++.
- Simultaneous allocate, response and pop are all legal in one cycle.
- dec_valid = (rd_ptr != fill_ptr). Head fields come from slot rd_ptr.
  - instr is forced to 0 when mal or fault is set.
  - instr, pc, mal_insn and fault_insn are all 0 when !dec_valid.
- f1_req_ready = !RST && !flush && ((wr_ptr−rd_ptr) + drop_cnt < DEPTH).
- Flush (takes priority over everything else):
  - Next cycle, all three pointers are 0.
  - drop_cnt_next = drop_cnt + (wr_ptr−fill_ptr) − imem_rvalid. A response arriving in the flush cycle counts as stale.
  - No allocate happens (ready is 0). A pop in the flush cycle is a don't-care (the entry is discarded anyway).
- drop_cnt width is log2(DEPTH)+1. It never exceeds DEPTH, because ready includes drop_cnt.

## Timing
- Reset values: all pointers 0, drop_cnt 0, slot contents 0. Consequently dec_valid=0, instr=0, pc=0, mal_insn=0, fault_insn=0. f1_req_ready=0 while RST is high and 1 in the first cycle after release.
- Latency: a response in cycle N gives dec_valid in cycle N+1 (registered fill, no bypass).
- Full: with wr−rd = DEPTH, ready=0. A pop in that cycle does not raise ready until the next cycle (ready is based on registered pointers).
- Empty with a fill and no pop: dec_valid rises the next cycle.
- Stall: with dec_stall=1, the head fields hold stable.
- Reset mid-operation: all state clears asynchronously. In-flight responses after release are not tracked; the memory must also be reset.

## Structure
- Shared package (rv32v_types_pkg): typedef fetch2_entry_t {word_t pc; word_t rdata; logic mal; logic fault}, plus the localparam for the pointer width. word_t comes from rv32i_types_pkg.
- One sub-module, rv32v_fetch2_ring, holds the entry storage and the three pointers. The top level holds drop_cnt, the handshake logic and the output masking.

## Test plan
- Basic flow: issue pc 0x100 and 0x104. Responses 0x00000013 and 0x00A00093 arrive on consecutive cycles with dec_stall=0. Required: dec_valid for 2 cycles, starting 1 cycle after each response, in order with matching pc values.
- Full/backpressure (DEPTH=2): dec_stall=1, issue 2 requests, both respond. Required: ready=0 after the 2nd accept and head stable at pc 0x100. Then release stall: one pop per cycle, and ready rises 1 cycle after the first pop.
- Misaligned/fault: issue pc 0x102 with a normal response, then pc 0x108 with imem_error=1 and rdata 0xDEADBEEF. Required: first head mal_insn=1, instr=0; second head fault_insn=1, instr=0.
- Flush with in-flight requests: issue 2 requests, then assert flush with no responses yet. Required: next cycle dec_valid=0, drop_cnt=2. The 2 late responses are dropped, and a new request at pc 0x200 is delivered with the correct data.
- Flush coincident with a response: 2 outstanding, flush and imem_rvalid in the same cycle. Required: drop_cnt=1, and only the following response is dropped.
- Async reset mid-stream: assert RST between clock edges while 2 entries are buffered. Required: dec_valid=0 immediately (asynchronously, before the next edge) and all outputs 0. After release, ready=1 and a new request flows normally.
